// File: rtl/mm_pkg.sv
// Shared types and helpers for the matrix-multiply write-back path.
package mm_pkg;

  typedef enum logic {IDLE, EMIT} ser_state_e;

  // Widest element any write-back stage may hand to narrow_sat
  localparam int unsigned NARROW_MAX_W = 64;

  // Narrow x to out_w bits; returns {sat_flag, value} with value zero-padded to NARROW_MAX_W
  function automatic logic [NARROW_MAX_W:0] narrow_sat(
    input logic [NARROW_MAX_W-1:0] x,
    input int unsigned             out_w,
    input logic                    sat_en
  );
    logic [NARROW_MAX_W-1:0] max_val;
    if (out_w >= NARROW_MAX_W) max_val = '1;
    else                       max_val = (NARROW_MAX_W'(1) << out_w) - NARROW_MAX_W'(1);
    if (sat_en && (x > max_val)) narrow_sat = {1'b1, max_val};
    else                         narrow_sat = {1'b0, x & max_val};
  endfunction

endpackage

// File: rtl/element_narrower.sv
// Combinational narrowing of one unsigned C element to OUT_WIDTH, with optional clamp.
module element_narrower #(
  parameter int unsigned C_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH = 16,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic [C_WIDTH-1:0]   x,
  output logic [OUT_WIDTH-1:0] y_c,
  output logic                 sat_c
);
  import mm_pkg::*;

  generate
    if (OUT_WIDTH >= C_WIDTH) begin : g_widen
      assign y_c   = OUT_WIDTH'(x);
      assign sat_c = 1'b0;
    end else begin : g_narrow
      logic [NARROW_MAX_W:0] res;
      logic                  unused_hi;

      assign res       = narrow_sat(NARROW_MAX_W'(x), OUT_WIDTH, SATURATE);
      assign y_c       = res[OUT_WIDTH-1:0];
      assign sat_c     = res[NARROW_MAX_W];
      // Bits above OUT_WIDTH are always zero after narrowing
      assign unused_hi = ^res[NARROW_MAX_W-1:OUT_WIDTH];
    end
  endgenerate

endmodule

// File: rtl/result_serializer.sv
// Drains N-wide C tile vectors and re-emits them one tagged, narrowed element per beat.
module result_serializer #(
  parameter int unsigned N         = 4,
  parameter int unsigned C_WIDTH   = 32,
  parameter int unsigned OUT_WIDTH = 16,
  parameter bit          SATURATE  = 1'b1,
  parameter int unsigned IDX_BITS  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_by_row,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      in_by_row,
  input  logic [N-1:0][C_WIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic [IDX_BITS-1:0]       out_row,
  output logic [IDX_BITS-1:0]       out_col,
  output logic                      out_sat,
  output logic                      out_last
);
  import mm_pkg::*;

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N - 1);

  ser_state_e                state,    state_n;
  logic [IDX_BITS-1:0]       vec_cnt,  vec_cnt_n;
  logic [IDX_BITS-1:0]       elem_cnt, elem_cnt_n;
  logic [IDX_BITS-1:0]       vec_idx,  vec_idx_n;
  logic                      mode_reg, mode_reg_n;
  logic [N-1:0][C_WIDTH-1:0] vec_buf,  vec_buf_n;

  logic in_fire;
  logic out_fire;
  logic elem_last;
  logic vec_done;

  // Handshake decode; in_ready reopens on the final element so vectors stream without bubbles
  assign out_valid = (state == EMIT);
  assign out_fire  = out_valid && out_ready;
  assign elem_last = (elem_cnt == LAST_IDX);
  assign vec_done  = out_fire && elem_last;
  assign in_ready  = (state == IDLE) || vec_done;
  assign in_fire   = in_valid && in_ready;

  // The processor samples the order only on a tile's first handshake, so mirror that here
  assign in_by_row = (vec_cnt == '0) ? cfg_by_row : mode_reg;

  assign out_row  = mode_reg ? vec_idx  : elem_cnt;
  assign out_col  = mode_reg ? elem_cnt : vec_idx;
  assign out_last = out_valid && (vec_idx == LAST_IDX) && elem_last;

  element_narrower #(
    .C_WIDTH  (C_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .SATURATE (SATURATE)
  ) u_narrow (
    .x    (vec_buf[elem_cnt]),
    .y_c  (out_data),
    .sat_c(out_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      vec_cnt  <= '0;
      elem_cnt <= '0;
      vec_idx  <= '0;
      mode_reg <= 1'b0;
      vec_buf  <= '0;
    end else begin
      state    <= state_n;
      vec_cnt  <= vec_cnt_n;
      elem_cnt <= elem_cnt_n;
      vec_idx  <= vec_idx_n;
      mode_reg <= mode_reg_n;
      vec_buf  <= vec_buf_n;
    end
  end

  always_comb begin
    state_n    = state;
    vec_cnt_n  = vec_cnt;
    elem_cnt_n = elem_cnt;
    vec_idx_n  = vec_idx;
    mode_reg_n = mode_reg;
    vec_buf_n  = vec_buf;

    case (state)
      IDLE:    if (in_fire) state_n = EMIT;
      EMIT:    if (vec_done && !in_fire) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    if (out_fire) elem_cnt_n = elem_last ? '0 : IDX_BITS'(elem_cnt + 1'b1);

    // A capture restarts the element walk even when it lands on the last element's fire
    if (in_fire) begin
      vec_buf_n  = in_data;
      vec_idx_n  = vec_cnt;
      elem_cnt_n = '0;
      vec_cnt_n  = (vec_cnt == LAST_IDX) ? '0 : IDX_BITS'(vec_cnt + 1'b1);
      if (vec_cnt == '0) mode_reg_n = cfg_by_row;
    end
  end

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer (N=4, 32->16 bits) with a SATURATE=0 twin.
module tb_result_serializer;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 32;
  localparam int unsigned OW = 16;
  localparam int unsigned IB = 2;

  logic               clk;
  logic               reset;
  logic               cfg_by_row;
  logic               in_valid;
  logic               in_ready;
  logic               in_by_row;
  logic [N-1:0][CW-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [OW-1:0]      out_data;
  logic [IB-1:0]      out_row;
  logic [IB-1:0]      out_col;
  logic               out_sat;
  logic               out_last;

  logic               ns_in_ready;
  logic               ns_in_by_row;
  logic               ns_out_valid;
  logic [OW-1:0]      ns_out_data;
  logic [IB-1:0]      ns_out_row;
  logic [IB-1:0]      ns_out_col;
  logic               ns_out_sat;
  logic               ns_out_last;

  result_serializer #(.N(N), .C_WIDTH(CW), .OUT_WIDTH(OW), .SATURATE(1'b1)) dut (
    .clk(clk), .reset(reset), .cfg_by_row(cfg_by_row),
    .in_valid(in_valid), .in_ready(in_ready), .in_by_row(in_by_row), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_sat(out_sat), .out_last(out_last)
  );

  result_serializer #(.N(N), .C_WIDTH(CW), .OUT_WIDTH(OW), .SATURATE(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .cfg_by_row(cfg_by_row),
    .in_valid(in_valid), .in_ready(ns_in_ready), .in_by_row(ns_in_by_row), .in_data(in_data),
    .out_valid(ns_out_valid), .out_ready(out_ready), .out_data(ns_out_data),
    .out_row(ns_out_row), .out_col(ns_out_col), .out_sat(ns_out_sat), .out_last(ns_out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] raw;
    logic [IB-1:0] row;
    logic [IB-1:0] col;
    logic          last;
  } beat_t;

  typedef struct {
    logic [N-1:0][CW-1:0] data;
    logic                 cfg;
  } vec_t;

  beat_t         bq[$];
  vec_t          vq[$];
  logic [CW-1:0] tile [N][N];

  int   total = 0;
  int   bad   = 0;
  bit   busy;
  int   elem;
  int   vcnt;
  logic tile_mode;
  int   popped;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] sat16(input logic [CW-1:0] x);
    return (x > 32'h0000_FFFF) ? 16'hFFFF : x[15:0];
  endfunction

  task automatic fill_ij();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        tile[i][j] = CW'(10 * i + j);
  endtask

  // Queue one tile: vectors for the driver, beats in emission order for the checker.
  // cfg_by_row toggles after vector 0 so a mid-tile change must be ignored.
  task automatic push_tile(input logic by_row);
    vec_t  v;
    beat_t b;
    for (int vi = 0; vi < N; vi++) begin
      v.cfg = (vi % 2 == 1) ? ~by_row : by_row;
      for (int e = 0; e < N; e++) begin
        v.data[e] = by_row ? tile[vi][e] : tile[e][vi];
        b.row  = by_row ? IB'(vi) : IB'(e);
        b.col  = by_row ? IB'(e)  : IB'(vi);
        b.raw  = tile[b.row][b.col];
        b.last = (vi == N - 1) && (e == N - 1);
        bq.push_back(b);
      end
      vq.push_back(v);
    end
  endtask

  task automatic run(input int budget, input bit rand_ready, input int stop_at);
    int    cyc;
    logic  exp_ir;
    beat_t b;
    cyc = 0;
    while (bq.size() > 0 || vq.size() > 0 || busy) begin
      if (stop_at >= 0 && popped == stop_at) return;
      if (cyc == budget) begin
        check("timeout", 1, 0);
        return;
      end
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(99) >= 30) : 1'b1;
      if (vq.size() > 0) begin
        in_valid   = 1'b1;
        in_data    = vq[0].data;
        cfg_by_row = vq[0].cfg;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      exp_ir = !busy || (out_ready && elem == N - 1);
      check("out_valid", out_valid, busy);
      check("in_ready", in_ready, exp_ir);
      check("ns_out_valid", ns_out_valid, busy);
      check("ns_in_ready", ns_in_ready, exp_ir);
      if (in_valid) begin
        check("in_by_row", in_by_row, (vcnt == 0) ? cfg_by_row : tile_mode);
        check("ns_in_by_row", ns_in_by_row, (vcnt == 0) ? cfg_by_row : tile_mode);
      end
      if (busy) begin
        b = bq[0];
        check("out_data", out_data, sat16(b.raw));
        check("out_sat", out_sat, b.raw > 32'h0000_FFFF);
        check("out_row", out_row, b.row);
        check("out_col", out_col, b.col);
        check("out_last", out_last, b.last);
        check("ns_out_data", ns_out_data, b.raw[15:0]);
        check("ns_out_sat", ns_out_sat, 1'b0);
        check("ns_out_row", ns_out_row, b.row);
        check("ns_out_col", ns_out_col, b.col);
        check("ns_out_last", ns_out_last, b.last);
      end else begin
        check("out_last_idle", out_last, 1'b0);
      end
      // Advance the reference for the fires that the coming edge will take
      if (busy && out_ready) begin
        void'(bq.pop_front());
        popped++;
        if (elem == N - 1) begin
          busy = 1'b0;
          elem = 0;
        end else begin
          elem++;
        end
      end
      if (in_valid && exp_ir) begin
        if (vcnt == 0) tile_mode = cfg_by_row;
        void'(vq.pop_front());
        busy = 1'b1;
        elem = 0;
        vcnt = (vcnt + 1) % N;
      end
      cyc++;
    end
  endtask

  initial begin
    reset      = 1'b1;
    cfg_by_row = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_data    = '0;
    busy       = 1'b0;
    elem       = 0;
    vcnt       = 0;
    tile_mode  = 1'b0;
    popped     = 0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_sat", out_sat, 1'b0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_out_row", out_row, 2'd0);
    check("rst_out_col", out_col, 2'd0);
    check("rst_in_by_row", in_by_row, 1'b0);
    reset = 1'b0;

    // Row order, full rate
    fill_ij();
    push_tile(1'b1);
    run(200, 1'b0, -1);

    // Column order, cfg toggling after vector 0
    push_tile(1'b0);
    run(200, 1'b0, -1);

    // Saturation boundaries
    fill_ij();
    tile[0][0] = 32'h0001_2345;
    tile[0][1] = 32'h0000_FFFF;
    tile[0][2] = 32'h0001_0000;
    tile[0][3] = 32'hFFFF_FFFF;
    tile[2][1] = 32'h0000_0000;
    push_tile(1'b1);
    run(200, 1'b0, -1);

    // Random data under backpressure, both orders
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        tile[i][j] = CW'($urandom_range(32'h0001_FFFF));
    push_tile(1'b1);
    push_tile(1'b0);
    run(800, 1'b1, -1);

    // Reset while showing vector 1 element 2, then a fresh column-order tile
    fill_ij();
    popped = 0;
    push_tile(1'b1);
    run(200, 1'b0, 7);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_last", out_last, 1'b0);
    check("mid_rst_out_data", out_data, 16'h0000);
    reset = 1'b0;
    bq.delete();
    vq.delete();
    busy      = 1'b0;
    elem      = 0;
    vcnt      = 0;
    tile_mode = 1'b0;
    push_tile(1'b0);
    run(200, 1'b0, -1);

    // Two tiles back-to-back, second tile switches order at its first handshake
    fill_ij();
    push_tile(1'b1);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        tile[i][j] = CW'(100 + 10 * i + j);
    push_tile(1'b0);
    run(400, 1'b0, -1);

    @(posedge clk);
    #2;
    check("end_out_valid", out_valid, 1'b0);
    check("end_in_ready", in_ready, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
